// File: rtl/game_pkg.sv
// Shared game definitions: phase encodings, update-step encodings, default
// geometry and the colour constants also used by the renderer.
package game_pkg;

    typedef enum logic [7:0] {
        STATE_IDLE     = 8'd0,
        STATE_SERVE    = 8'd1,
        STATE_PLAY     = 8'd2,
        STATE_POINT    = 8'd3,
        STATE_GAMEOVER = 8'd4
    } game_state_t;

    typedef enum logic [2:0] {
        U_IDLE,
        U_PADDLE,
        U_BALL,
        U_COLLIDE,
        U_PHASE
    } upd_state_t;

    localparam int DEF_SCREEN_W     = 800;
    localparam int DEF_SCREEN_H     = 600;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_W     = 10;
    localparam int DEF_PADDLE_H     = 80;
    localparam int DEF_PLAYER_X     = 40;
    localparam int DEF_COMPUTER_X   = 750;
    localparam int DEF_BALL_SPEED   = 4;
    localparam int DEF_PADDLE_SPEED = 4;
    localparam int DEF_AI_SPEED     = 3;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_WIN_SCORE    = 9;

    localparam logic [7:0] COLOUR_BG   = 8'h00;
    localparam logic [7:0] COLOUR_FG   = 8'hFF;
    localparam logic [7:0] COLOUR_NET  = 8'h92;

endpackage

// File: rtl/paddle_ai.sv
// Computer paddle: steps toward the ball centre by at most AI_SPEED per frame,
// clamped to the visible area. Purely combinational.
module paddle_ai
    import game_pkg::*;
#(
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int AI_SPEED  = DEF_AI_SPEED
)(
    input  logic [15:0] i_ballY,
    input  logic [15:0] i_curY,
    output logic [15:0] o_nextY
);

    localparam logic signed [17:0] OFFSET   = 18'(BALL_SIZE / 2 - PADDLE_H / 2);
    localparam logic signed [17:0] STEP_POS = 18'(AI_SPEED);
    localparam logic signed [17:0] STEP_NEG = 18'(-AI_SPEED);
    localparam logic signed [17:0] MAX_Y    = 18'(SCREEN_H - PADDLE_H);

    logic signed [17:0] w_target;
    logic signed [17:0] w_diff;
    logic signed [17:0] w_step;
    logic signed [17:0] w_next;

    always_comb begin
        w_target = $signed({2'b00, i_ballY}) + OFFSET;
        w_diff   = w_target - $signed({2'b00, i_curY});
        if (w_diff > STEP_POS)
            w_step = STEP_POS;
        else if (w_diff < STEP_NEG)
            w_step = STEP_NEG;
        else
            w_step = w_diff;
        w_next = $signed({2'b00, i_curY}) + w_step;
        if (w_next < 0)
            o_nextY = '0;
        else if (w_next > MAX_Y)
            o_nextY = MAX_Y[15:0];
        else
            o_nextY = w_next[15:0];
    end

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game state owner: on frameTick runs a four-step update
// (paddles, ball, collisions, phase) so renderer inputs only change in blanking.
module game_sequencer
    import game_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PLAYER_X     = DEF_PLAYER_X,
    parameter int COMPUTER_X   = DEF_COMPUTER_X,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int AI_SPEED     = DEF_AI_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
)(
    input  logic        pixelClock,
    input  logic        reset,
    input  logic        frameTick,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnStart,
    output logic [7:0]  gameState,
    output logic [15:0] ballX,
    output logic [15:0] ballY,
    output logic [15:0] playerPaddleY,
    output logic [15:0] computerPaddleY,
    output logic [7:0]  playerScore,
    output logic [7:0]  computerScore
);

    localparam logic [15:0] BALL_CX   = 16'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [15:0] BALL_CY   = 16'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [15:0] PAD_C     = 16'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [15:0] PAD_MAX   = 16'(SCREEN_H - PADDLE_H);
    localparam logic [15:0] PSPEED    = 16'(PADDLE_SPEED);
    localparam logic [15:0] BALL_MAXX = 16'(SCREEN_W - BALL_SIZE);
    localparam logic [15:0] BALL_MAXY = 16'(SCREEN_H - BALL_SIZE);
    localparam logic [15:0] P_HIT_X   = 16'(PLAYER_X + PADDLE_W);
    localparam logic [15:0] C_HIT_X   = 16'(COMPUTER_X - BALL_SIZE);
    localparam logic [16:0] BALL_SZ17 = 17'(BALL_SIZE);
    localparam logic [16:0] PAD_H17   = 17'(PADDLE_H);
    localparam logic signed [16:0] S_SPEED  = 17'(BALL_SPEED);
    localparam logic signed [16:0] S_NSPEED = 17'(-BALL_SPEED);
    localparam logic signed [16:0] S_BALLSZ = 17'(BALL_SIZE);
    localparam logic signed [16:0] S_PX     = 17'(PLAYER_X);
    localparam logic signed [16:0] S_PHIT   = 17'(PLAYER_X + PADDLE_W);
    localparam logic signed [16:0] S_CX     = 17'(COMPUTER_X);
    localparam logic signed [16:0] S_CEND   = 17'(COMPUTER_X + PADDLE_W);
    localparam logic signed [16:0] S_MAXX   = 17'(SCREEN_W - BALL_SIZE);
    localparam logic signed [16:0] S_MAXY   = 17'(SCREEN_H - BALL_SIZE);
    localparam logic [7:0]  WIN8       = 8'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);

    upd_state_t         r_upd,      w_upd;
    game_state_t        r_state,    w_state;
    logic [15:0]        r_ballX,    w_ballX;
    logic [15:0]        r_ballY,    w_ballY;
    logic [15:0]        r_padP,     w_padP;
    logic [15:0]        r_padC,     w_padC;
    logic [7:0]         r_scoreP,   w_scoreP;
    logic [7:0]         r_scoreC,   w_scoreC;
    logic [7:0]         r_serveCnt, w_serveCnt;
    logic               r_dxNeg,    w_dxNeg;
    logic               r_dyNeg,    w_dyNeg;
    logic               r_startPrev, w_startPrev;
    logic               r_ptP,      w_ptP;
    logic               r_ptC,      w_ptC;
    logic               r_lastP,    w_lastP;
    logic signed [16:0] r_nextX,    w_nextX;
    logic signed [16:0] r_nextY,    w_nextY;
    logic [15:0]        w_aiY;
    logic               w_startEdge;
    logic               w_hitP;
    logic               w_hitC;

    paddle_ai #(
        .SCREEN_H (SCREEN_H),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_H (PADDLE_H),
        .AI_SPEED (AI_SPEED)
    ) u_ai (
        .i_ballY(r_ballY),
        .i_curY (r_padC),
        .o_nextY(w_aiY)
    );

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_upd       <= U_IDLE;
            r_state     <= STATE_IDLE;
            r_ballX     <= BALL_CX;
            r_ballY     <= BALL_CY;
            r_padP      <= PAD_C;
            r_padC      <= PAD_C;
            r_scoreP    <= '0;
            r_scoreC    <= '0;
            r_serveCnt  <= '0;
            r_dxNeg     <= 1'b0;
            r_dyNeg     <= 1'b0;
            r_startPrev <= 1'b0;
            r_ptP       <= 1'b0;
            r_ptC       <= 1'b0;
            r_lastP     <= 1'b0;
            r_nextX     <= '0;
            r_nextY     <= '0;
        end else begin
            r_upd       <= w_upd;
            r_state     <= w_state;
            r_ballX     <= w_ballX;
            r_ballY     <= w_ballY;
            r_padP      <= w_padP;
            r_padC      <= w_padC;
            r_scoreP    <= w_scoreP;
            r_scoreC    <= w_scoreC;
            r_serveCnt  <= w_serveCnt;
            r_dxNeg     <= w_dxNeg;
            r_dyNeg     <= w_dyNeg;
            r_startPrev <= w_startPrev;
            r_ptP       <= w_ptP;
            r_ptC       <= w_ptC;
            r_lastP     <= w_lastP;
            r_nextX     <= w_nextX;
            r_nextY     <= w_nextY;
        end
    end

    // Paddle overlap tests use the pre-move ballY and the paddles moved this frame
    always_comb begin
        w_hitP = r_dxNeg && (r_nextX <= S_PHIT) && (r_nextX + S_BALLSZ > S_PX)
              && ({1'b0, r_ballY} + BALL_SZ17 > {1'b0, r_padP})
              && ({1'b0, r_ballY} < {1'b0, r_padP} + PAD_H17);
        w_hitC = !r_dxNeg && (r_nextX + S_BALLSZ >= S_CX) && (r_nextX < S_CEND)
              && ({1'b0, r_ballY} + BALL_SZ17 > {1'b0, r_padC})
              && ({1'b0, r_ballY} < {1'b0, r_padC} + PAD_H17);
    end

    always_comb begin
        w_upd       = r_upd;
        w_state     = r_state;
        w_ballX     = r_ballX;
        w_ballY     = r_ballY;
        w_padP      = r_padP;
        w_padC      = r_padC;
        w_scoreP    = r_scoreP;
        w_scoreC    = r_scoreC;
        w_serveCnt  = r_serveCnt;
        w_dxNeg     = r_dxNeg;
        w_dyNeg     = r_dyNeg;
        w_startPrev = r_startPrev;
        w_ptP       = r_ptP;
        w_ptC       = r_ptC;
        w_lastP     = r_lastP;
        w_nextX     = r_nextX;
        w_nextY     = r_nextY;
        w_startEdge = btnStart & ~r_startPrev;

        case (r_upd)
            U_IDLE: begin
                if (frameTick)
                    w_upd = U_PADDLE;
            end
            U_PADDLE: begin
                w_upd = U_BALL;
                if (r_state == STATE_SERVE || r_state == STATE_PLAY) begin
                    if (btnUp && !btnDown)
                        w_padP = (r_padP < PSPEED) ? '0 : r_padP - PSPEED;
                    else if (btnDown && !btnUp)
                        w_padP = (r_padP > PAD_MAX - PSPEED) ? PAD_MAX : r_padP + PSPEED;
                    w_padC = w_aiY;
                end
            end
            U_BALL: begin
                w_upd   = U_COLLIDE;
                w_nextX = $signed({1'b0, r_ballX}) + (r_dxNeg ? S_NSPEED : S_SPEED);
                w_nextY = $signed({1'b0, r_ballY}) + (r_dyNeg ? S_NSPEED : S_SPEED);
            end
            U_COLLIDE: begin
                w_upd = U_PHASE;
                w_ptP = 1'b0;
                w_ptC = 1'b0;
                if (r_state == STATE_PLAY) begin
                    if (r_nextY <= 0) begin
                        w_ballY = '0;
                        w_dyNeg = 1'b0;
                    end else if (r_nextY >= S_MAXY) begin
                        w_ballY = BALL_MAXY;
                        w_dyNeg = 1'b1;
                    end else begin
                        w_ballY = r_nextY[15:0];
                    end
                    if (w_hitP) begin
                        w_ballX = P_HIT_X;
                        w_dxNeg = 1'b0;
                    end else if (w_hitC) begin
                        w_ballX = C_HIT_X;
                        w_dxNeg = 1'b1;
                    end else if (r_nextX <= 0) begin
                        w_ballX = '0;
                        w_ptC   = 1'b1;
                    end else if (r_nextX >= S_MAXX) begin
                        w_ballX = BALL_MAXX;
                        w_ptP   = 1'b1;
                    end else begin
                        w_ballX = r_nextX[15:0];
                    end
                end
            end
            U_PHASE: begin
                w_upd       = U_IDLE;
                w_startPrev = btnStart;
                case (r_state)
                    STATE_IDLE, STATE_GAMEOVER: begin
                        if (w_startEdge) begin
                            w_state    = STATE_SERVE;
                            w_scoreP   = '0;
                            w_scoreC   = '0;
                            w_ballX    = BALL_CX;
                            w_ballY    = BALL_CY;
                            w_serveCnt = '0;
                        end
                    end
                    STATE_SERVE: begin
                        if (r_serveCnt >= SERVE_LAST) begin
                            w_state    = STATE_PLAY;
                            w_serveCnt = '0;
                        end else begin
                            w_serveCnt = r_serveCnt + 8'd1;
                        end
                    end
                    STATE_PLAY: begin
                        if (r_ptC) begin
                            w_scoreC = (r_scoreC >= WIN8) ? WIN8 : r_scoreC + 8'd1;
                            w_lastP  = 1'b0;
                            w_state  = STATE_POINT;
                        end else if (r_ptP) begin
                            w_scoreP = (r_scoreP >= WIN8) ? WIN8 : r_scoreP + 8'd1;
                            w_lastP  = 1'b1;
                            w_state  = STATE_POINT;
                        end
                    end
                    STATE_POINT: begin
                        if ((r_lastP ? r_scoreP : r_scoreC) >= WIN8) begin
                            w_state = STATE_GAMEOVER;
                        end else begin
                            // serve travels toward whoever lost the point
                            w_state    = STATE_SERVE;
                            w_ballX    = BALL_CX;
                            w_ballY    = BALL_CY;
                            w_serveCnt = '0;
                            w_dxNeg    = ~r_lastP;
                        end
                    end
                    default: w_state = STATE_IDLE;
                endcase
            end
            default: w_upd = U_IDLE;
        endcase
    end

    assign gameState       = r_state;
    assign ballX           = r_ballX;
    assign ballY           = r_ballY;
    assign playerPaddleY   = r_padP;
    assign computerPaddleY = r_padC;
    assign playerScore     = r_scoreP;
    assign computerScore   = r_scoreC;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: hand-computed vector table for the opening frames,
// then a frame-level reference model feeding a scoreboard through full games.
module tb_game_sequencer;

    logic        pixelClock = 1'b0;
    logic        reset = 1'b1;
    logic        frameTick = 1'b0;
    logic        btnUp = 1'b0;
    logic        btnDown = 1'b0;
    logic        btnStart = 1'b0;
    logic [7:0]  gameState;
    logic [15:0] ballX, ballY, playerPaddleY, computerPaddleY;
    logic [7:0]  playerScore, computerScore;

    game_sequencer dut (
        .pixelClock     (pixelClock),
        .reset          (reset),
        .frameTick      (frameTick),
        .btnUp          (btnUp),
        .btnDown        (btnDown),
        .btnStart       (btnStart),
        .gameState      (gameState),
        .ballX          (ballX),
        .ballY          (ballY),
        .playerPaddleY  (playerPaddleY),
        .computerPaddleY(computerPaddleY),
        .playerScore    (playerScore),
        .computerScore  (computerScore)
    );

    always #5 pixelClock = ~pixelClock;

    typedef struct packed {
        int st; int bx; int by; int pp; int cp; int ps; int cs;
    } exp_t;

    typedef struct {
        logic up; logic down; logic start; int n; exp_t e;
    } vec_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    int m_st, m_bx, m_by, m_pp, m_cp, m_ps, m_cs, m_cnt;
    bit m_dxn, m_dyn, m_sprev, m_lastp;

    function automatic exp_t mk(int st, int bx, int by, int pp, int cp, int ps, int cs);
        exp_t e;
        e.st = st; e.bx = bx; e.by = by; e.pp = pp; e.cp = cp; e.ps = ps; e.cs = cs;
        return e;
    endfunction

    function automatic exp_t dut_now();
        return mk(int'(gameState), int'(ballX), int'(ballY), int'(playerPaddleY),
                  int'(computerPaddleY), int'(playerScore), int'(computerScore));
    endfunction

    function automatic exp_t model_exp();
        return mk(m_st, m_bx, m_by, m_pp, m_cp, m_ps, m_cs);
    endfunction

    task automatic model_reset();
        m_st = 0; m_bx = 396; m_by = 296; m_pp = 260; m_cp = 260;
        m_ps = 0; m_cs = 0; m_cnt = 0;
        m_dxn = 0; m_dyn = 0; m_sprev = 0; m_lastp = 0;
    endtask

    task automatic model_step(input bit up, input bit down, input bit start);
        int tgt, d, nx, ny;
        bit ptc, ptp, sedge;
        ptc = 0; ptp = 0;
        if (m_st == 1 || m_st == 2) begin
            if (up && !down) m_pp = (m_pp - 4 < 0) ? 0 : m_pp - 4;
            else if (down && !up) m_pp = (m_pp + 4 > 520) ? 520 : m_pp + 4;
            tgt = m_by + 4 - 40;
            d = tgt - m_cp;
            if (d > 3) d = 3;
            else if (d < -3) d = -3;
            m_cp = m_cp + d;
            if (m_cp < 0) m_cp = 0;
            if (m_cp > 520) m_cp = 520;
        end
        if (m_st == 2) begin
            nx = m_bx + (m_dxn ? -4 : 4);
            ny = m_by + (m_dyn ? -4 : 4);
            if (ny <= 0) begin ny = 0; m_dyn = 0; end
            else if (ny >= 592) begin ny = 592; m_dyn = 1; end
            if (m_dxn && nx <= 50 && nx + 8 > 40 && m_by + 8 > m_pp && m_by < m_pp + 80) begin
                nx = 50; m_dxn = 0;
            end else if (!m_dxn && nx + 8 >= 750 && nx < 760 && m_by + 8 > m_cp && m_by < m_cp + 80) begin
                nx = 742; m_dxn = 1;
            end else if (nx <= 0) begin
                nx = 0; ptc = 1;
            end else if (nx >= 792) begin
                nx = 792; ptp = 1;
            end
            m_bx = nx; m_by = ny;
        end
        sedge = start && !m_sprev;
        m_sprev = start;
        if (m_st == 0 || m_st == 4) begin
            if (sedge) begin
                m_st = 1; m_ps = 0; m_cs = 0; m_bx = 396; m_by = 296; m_cnt = 0;
            end
        end else if (m_st == 1) begin
            if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end else if (m_st == 2) begin
            if (ptc) begin
                if (m_cs < 9) m_cs = m_cs + 1;
                m_lastp = 0; m_st = 3;
            end else if (ptp) begin
                if (m_ps < 9) m_ps = m_ps + 1;
                m_lastp = 1; m_st = 3;
            end
        end else if (m_st == 3) begin
            if ((m_lastp ? m_ps : m_cs) == 9) begin
                m_st = 4;
            end else begin
                m_st = 1; m_bx = 396; m_by = 296; m_cnt = 0; m_dxn = !m_lastp;
            end
        end
    endtask

    task automatic cmp_rec(input string name, input exp_t got, input exp_t want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got st=%0d ball=(%0d,%0d) pads=(%0d,%0d) score=(%0d,%0d) want st=%0d ball=(%0d,%0d) pads=(%0d,%0d) score=(%0d,%0d)",
                     name, got.st, got.bx, got.by, got.pp, got.cp, got.ps, got.cs,
                     want.st, want.bx, want.by, want.pp, want.cp, want.ps, want.cs);
        end
    endtask

    task automatic check_val(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // One frame: pulse frameTick, let the 4-step update finish, then score it
    task automatic run_frame(input logic up, input logic down, input logic start,
                             input bit chk, input exp_t e, input string name);
        exp_t want;
        btnUp = up; btnDown = down; btnStart = start;
        @(negedge pixelClock);
        frameTick = 1'b1;
        if (chk) sb.push_back(e);
        @(negedge pixelClock);
        frameTick = 1'b0;
        repeat (4) @(negedge pixelClock);
        if (chk) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                want = sb.pop_front();
                cmp_rec(name, dut_now(), want);
            end
        end
    endtask

    task automatic set_vec(input int i, input logic up, input logic down, input logic start,
                           input int n, input exp_t e);
        vecs[i].up = up; vecs[i].down = down; vecs[i].start = start;
        vecs[i].n = n; vecs[i].e = e;
    endtask

    initial begin
        bit done;
        bit dn;

        set_vec(0, 0, 0, 0, 3,  mk(0, 396, 296, 260, 260, 0, 0));
        set_vec(1, 0, 0, 1, 1,  mk(1, 396, 296, 260, 260, 0, 0));
        set_vec(2, 0, 0, 0, 59, mk(1, 396, 296, 260, 260, 0, 0));
        set_vec(3, 0, 0, 0, 1,  mk(2, 396, 296, 260, 260, 0, 0));
        set_vec(4, 0, 0, 0, 1,  mk(2, 400, 300, 260, 260, 0, 0));
        set_vec(5, 0, 1, 0, 1,  mk(2, 404, 304, 264, 263, 0, 0));
        set_vec(6, 1, 1, 0, 1,  mk(2, 408, 308, 264, 266, 0, 0));
        set_vec(7, 1, 0, 0, 1,  mk(2, 412, 312, 260, 269, 0, 0));

        repeat (3) @(negedge pixelClock);
        cmp_rec("reset_state", dut_now(), mk(0, 396, 296, 260, 260, 0, 0));
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 8; i++) begin
            for (int f = 0; f < vecs[i].n; f++) begin
                model_step(vecs[i].up, vecs[i].down, vecs[i].start);
                run_frame(vecs[i].up, vecs[i].down, vecs[i].start,
                          (f == vecs[i].n - 1), vecs[i].e, $sformatf("vec%0d", i));
            end
        end

        for (int f = 0; f < 70; f++) begin
            model_step(0, 1, 0);
            run_frame(0, 1, 0, 1'b1, model_exp(), "pad_down");
        end
        check_val("pad_clamp_bottom", int'(playerPaddleY), 520);
        for (int f = 0; f < 3; f++) begin
            model_step(1, 1, 0);
            run_frame(1, 1, 0, 1'b1, model_exp(), "pad_both");
        end
        check_val("pad_both_hold", int'(playerPaddleY), 520);

        // Start held through the rallies so game over sees no fresh edge
        done = 0;
        for (int f = 0; f < 12000 && !done; f++) begin
            dn = (m_by < 296);
            model_step(!dn, dn, 1'b1);
            run_frame(!dn, dn, 1'b1, 1'b1, model_exp(), "rally");
            if (m_st == 4) done = 1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL gameover_timeout: got state %0d want 4", gameState);
        end
        check_val("winner_at_9", int'(playerScore == 8'd9 || computerScore == 8'd9), 1);

        for (int f = 0; f < 3; f++) begin
            model_step(0, 0, 1);
            run_frame(0, 0, 1, 1'b1, model_exp(), "gameover_held");
        end
        check_val("gameover_hold", int'(gameState), 4);
        model_step(0, 0, 0);
        run_frame(0, 0, 0, 1'b1, model_exp(), "gameover_release");
        model_step(0, 0, 1);
        run_frame(0, 0, 1, 1'b1, model_exp(), "restart");
        check_val("restart_state", int'(gameState), 1);
        check_val("restart_pscore", int'(playerScore), 0);
        check_val("restart_cscore", int'(computerScore), 0);

        btnDown = 1'b1;
        btnStart = 1'b0;
        @(negedge pixelClock);
        frameTick = 1'b1;
        @(negedge pixelClock);
        frameTick = 1'b0;
        reset = 1'b1;
        @(negedge pixelClock);
        cmp_rec("reset_mid_update", dut_now(), mk(0, 396, 296, 260, 260, 0, 0));
        reset = 1'b0;
        btnDown = 1'b0;
        model_reset();
        repeat (2) @(negedge pixelClock);
        model_step(0, 0, 0);
        run_frame(0, 0, 0, 1'b1, model_exp(), "after_reset_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Owns all game state consumed by the screen renderer: game phase, ball position and velocity, both paddle positions and both scores. Advances the game once per video frame on a frameTick pulse issued at the start of vertical blank. Updates finish within blanking, so renderer inputs never change mid-frame. Drives the renderer's gameState, ballX/Y, playerPaddleY, computerPaddleY, playerScore and computerScore inputs directly.

Parameters:
SCREEN_W, 800, visible width in pixels
SCREEN_H, 600, visible height in pixels
BALL_SIZE, 8, ball width and height
PADDLE_W, 10, paddle width
PADDLE_H, 80, paddle height
PLAYER_X, 40, player paddle left edge
COMPUTER_X, 750, computer paddle left edge
BALL_SPEED, 4, ball |dx| and |dy| per frame
PADDLE_SPEED, 4, player paddle step per frame
AI_SPEED, 3, computer paddle max step per frame
SERVE_FRAMES, 60, frames the ball is held centred before play
WIN_SCORE, 9, score that ends the game (must be ≤9, renderer digit limit)

Ports:
pixelClock  in  1  single clock; synchronous reset, active-high
reset  in  1  synchronous, active-high
frameTick  in  1  one-cycle pulse per frame at start of vertical blank
btnUp  in  1  player up, level, synchronised upstream
btnDown  in  1  player down, level
btnStart  in  1  start/restart, level
gameState  out  8  stateIdle=0, stateServe=1, statePlay=2, statePoint=3, stateGameOver=4
ballX, ballY  out  16 each  ball top-left corner
playerPaddleY, computerPaddleY  out  16 each  paddle top edges
playerScore, computerScore  out  8 each  0..WIN_SCORE

Behaviour:
- Reset (sync, overrides everything, aborts an in-progress update): gameState=stateIdle; ballX=(SCREEN_W-BALL_SIZE)/2=396; ballY=(SCREEN_H-BALL_SIZE)/2=296; both paddles (SCREEN_H-PADDLE_H)/2=260; scores 0; dx=+BALL_SPEED, dy=+BALL_SPEED; serve counter 0; startPrev=0.
- Update sequencer: idle until frameTick, then steps U_PADDLE → U_BALL → U_COLLIDE → U_PHASE, one cycle each, then returns to idle. Outputs change only in these 4 cycles. A frameTick arriving while busy is ignored.
- Start edge: startEdge = btnStart & ~startPrev. startPrev is sampled in U_PHASE only, so the edge is frame-rate.
- stateIdle: startEdge → stateServe. Scores are cleared and the ball is centred.
- stateServe: ball held centred. Counter increments per frame. When it reaches SERVE_FRAMES-1, go to statePlay and clear the counter. Paddles still move.
- statePlay:
  - U_PADDLE, player paddle: btnUp only → y-PADDLE_SPEED; btnDown only → y+PADDLE_SPEED; both or neither → hold. Clamp to [0, SCREEN_H-PADDLE_H].
  - U_PADDLE, computer paddle: target = ballY + BALL_SIZE/2 - PADDLE_H/2. Step toward the target by min(|diff|, AI_SPEED), with the same clamp.
  - U_BALL: next = pos + velocity, computed as 17-bit signed so negatives are detectable.
  - U_COLLIDE, walls: nextY ≤ 0 → y=0, dy=+. nextY ≥ SCREEN_H-BALL_SIZE → y=SCREEN_H-BALL_SIZE, dy=-.
  - U_COLLIDE, player paddle: dx<0, nextX ≤ PLAYER_X+PADDLE_W, nextX+BALL_SIZE > PLAYER_X, and vertical overlap (ballY+BALL_SIZE > padY and ballY < padY+PADDLE_H) → x=PLAYER_X+PADDLE_W, dx=+.
  - U_COLLIDE, computer paddle: mirror case → x=COMPUTER_X-BALL_SIZE, dx=-.
  - U_COLLIDE, misses: nextX ≤ 0 → x=0, flag computer point. nextX ≥ SCREEN_W-BALL_SIZE → x clamped, flag player point.
  - Precedence: paddle hit beats edge miss; wall and paddle may both apply in the same frame.
  - U_PHASE: a point flag → statePoint.
- statePoint (one frame): increment the scorer's score, saturating at WIN_SCORE. Result == WIN_SCORE → stateGameOver, else → stateServe. On serve, dx points toward the player who lost the point and dy is kept.
- stateGameOver: ball and paddles frozen. startEdge → stateServe with scores cleared. A held btnStart never auto-restarts.
- Scores never exceed WIN_SCORE. Positions are always in range after U_COLLIDE.

Decomposition:
- Shared package game_pkg: gameState encodings; screen, ball and paddle geometry; the colour constants already shared with the renderer.
- One sub-module, paddle_ai: computer paddle step/clamp. Inputs: ballY, current Y. Output: next Y. Combinational, registered by the parent in U_PADDLE.

Test Plan:
- Reset, then 3 frameTicks with no buttons → gameState=0, ball (396,296), paddles 260, scores 0.
- btnStart pulse, then 60 ticks → gameState 1 for 60 frames then 2. Ball holds (396,296) during serve, then moves +4,+4 per frame.
- btnDown held 70 frames from 260 → playerPaddleY clamps at 520. btnUp+btnDown together → no move.
- Ball forced toward the top wall with ballY=2, dy=-4 → ballY=0, dy=+4 next frame. Ball at x=54, dx=-4 with the paddle overlapping → x=50, dx=+4.
- Player paddle moved clear; ball exits left → one frame of state 3, computerScore=1, then state 1 with dx=-4. Repeat to 9 → state 4 with ball frozen. btnStart held → stays in 4; release and press → state 1, scores 0.
- Reset asserted the cycle after frameTick (mid-update) → all outputs equal reset values on the next cycle, and no score change.
